// File: rtl/store_sequencer_if.sv
// Handshake, register-file, ALU and memory-write bundle for the store sequencer.
// master = the sequencer; slave = the instruction source, register file, ALU and memory.
interface store_sequencer_if;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instruction;
    logic [3:0]  rf_raddr1;
    logic [3:0]  rf_raddr2;
    logic [31:0] rf_rdata1;
    logic [31:0] rf_rdata2;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_control;
    logic [31:0] alu_result;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        mem_ack;
    logic        busy;
    logic        done;
    logic        illegal;
    logic        timeout;
    logic        misaligned;
    logic [15:0] store_count;

    modport master (
        input  instr_valid, instruction, rf_rdata1, rf_rdata2, alu_result, mem_ack,
        output instr_ready, rf_raddr1, rf_raddr2, alu_a, alu_b, alu_control,
               mem_addr, mem_wdata, mem_we, busy, done, illegal, timeout,
               misaligned, store_count
    );

    modport slave (
        output instr_valid, instruction, rf_rdata1, rf_rdata2, alu_result, mem_ack,
        input  instr_ready, rf_raddr1, rf_raddr2, alu_a, alu_b, alu_control,
               mem_addr, mem_wdata, mem_we, busy, done, illegal, timeout,
               misaligned, store_count
    );
endinterface

// File: rtl/store_sequencer.sv
// Multi-cycle store sequencer: IDLE -> DECODE -> READ -> EXEC -> MEM -> DONE.
// Define STORE_ALIGN_CHECK_EN to reject word-misaligned addresses before the write.
module store_sequencer #(
    parameter logic [3:0] STORE_OPCODE = 4'b1011,
    parameter logic [2:0] ALU_ADD      = 3'b010,
    parameter int         MAX_WAIT     = 15
) (
    input  logic               clk,
    input  logic               reset,
    store_sequencer_if.master  bus
);
    localparam int WW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [WW-1:0] WAIT_LAST = WW'(MAX_WAIT - 1);

    typedef enum logic [2:0] {IDLE, DECODE, READ, EXEC, MEM, DONE} state_e;

    function automatic logic [31:0] sext4(input logic [3:0] v);
        return {{28{v[3]}}, v};
    endfunction

    state_e        state_q;
    logic [15:0]   instr_q;
    logic [31:0]   base_q;
    logic [31:0]   data_q;
    logic [31:0]   mem_addr_q;
    logic [31:0]   mem_wdata_q;
    logic [2:0]    alu_ctl_q;
    logic          mem_we_q;
    logic          done_q;
    logic          illegal_q;
    logic          timeout_q;
    logic          misaligned_q;
    logic [WW-1:0] wait_q;
    logic [WW-1:0] wait_d;
    logic [15:0]   store_count_q;
    logic [15:0]   store_count_d;

    assign wait_d        = wait_q + WW'(1);
    assign store_count_d = store_count_q + 16'd1;

    // Sequencer FSM with its datapath registers and single-cycle status pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            instr_q       <= 16'h0000;
            base_q        <= 32'h0000_0000;
            data_q        <= 32'h0000_0000;
            mem_addr_q    <= 32'h0000_0000;
            mem_wdata_q   <= 32'h0000_0000;
            alu_ctl_q     <= 3'b000;
            mem_we_q      <= 1'b0;
            done_q        <= 1'b0;
            illegal_q     <= 1'b0;
            timeout_q     <= 1'b0;
            misaligned_q  <= 1'b0;
            wait_q        <= '0;
            store_count_q <= 16'h0000;
        end else begin
            done_q       <= 1'b0;
            illegal_q    <= 1'b0;
            timeout_q    <= 1'b0;
            misaligned_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.instr_valid) begin
                        instr_q   <= bus.instruction;
                        illegal_q <= (bus.instruction[15:12] != STORE_OPCODE);
                        state_q   <= DECODE;
                    end
                end
                DECODE: begin
                    if (instr_q[15:12] != STORE_OPCODE) begin
                        state_q <= IDLE;
                    end else begin
                        state_q <= READ;
                    end
                end
                READ: begin
                    base_q    <= bus.rf_rdata1;
                    data_q    <= bus.rf_rdata2;
                    alu_ctl_q <= ALU_ADD;
                    state_q   <= EXEC;
                end
                EXEC: begin
                    alu_ctl_q <= 3'b000;
`ifdef STORE_ALIGN_CHECK_EN
                    if (bus.alu_result[1:0] != 2'b00) begin
                        misaligned_q <= 1'b1;
                        state_q      <= IDLE;
                    end else begin
`else
                    begin
`endif
                        mem_addr_q  <= bus.alu_result;
                        mem_wdata_q <= data_q;
                        mem_we_q    <= 1'b1;
                        wait_q      <= '0;
                        state_q     <= MEM;
                    end
                end
                MEM: begin
                    // An ack arriving on the last allowed cycle still completes the store.
                    if (bus.mem_ack) begin
                        mem_we_q <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= DONE;
                    end else if (wait_q == WAIT_LAST) begin
                        wait_q    <= wait_d;
                        mem_we_q  <= 1'b0;
                        timeout_q <= 1'b1;
                        state_q   <= IDLE;
                    end else begin
                        wait_q <= wait_d;
                    end
                end
                DONE: begin
                    store_count_q <= store_count_d;
                    state_q       <= IDLE;
                end
                default: begin
                    mem_we_q <= 1'b0;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

    // Ready is withheld while reset is asserted so nothing is offered mid-reset.
    assign bus.instr_ready = reset && (state_q == IDLE);
    assign bus.busy        = (state_q != IDLE);
    assign bus.rf_raddr1   = instr_q[11:8];
    assign bus.rf_raddr2   = instr_q[7:4];
    assign bus.alu_a       = base_q;
    assign bus.alu_b       = sext4(instr_q[3:0]);
    assign bus.alu_control = alu_ctl_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wdata   = mem_wdata_q;
    assign bus.mem_we      = mem_we_q;
    assign bus.done        = done_q;
    assign bus.illegal     = illegal_q;
    assign bus.timeout     = timeout_q;
    assign bus.misaligned  = misaligned_q;
    assign bus.store_count = store_count_q;
endmodule

// File: tb/tb_store_sequencer.sv
// Self-checking bench for store_sequencer: directed vector table, reset/wrap
// sequences and randomized stores checked against a transaction-level model.
module tb_store_sequencer;
    localparam int MAX_WAIT = 15;
    localparam int K_DONE = 0;
    localparam int K_ILL  = 1;
    localparam int K_TO   = 2;
    localparam int K_MIS  = 3;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    store_sequencer_if bus();
    store_sequencer dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    logic [31:0] regs [16];
    int          n_pass  = 0;
    int          n_total = 0;
    logic [15:0] exp_count = 16'h0000;

    // Register file and adder behaving as ideal combinational slaves.
    always_comb begin
        bus.rf_rdata1  = regs[bus.rf_raddr1];
        bus.rf_rdata2  = regs[bus.rf_raddr2];
        bus.alu_result = bus.alu_a + bus.alu_b;
    end

    typedef struct {
        logic [15:0] ins;
        logic [31:0] base_v;
        logic [31:0] data_v;
        int          dly;
        int          kind;
        logic [31:0] addr;
    } vec_t;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    endtask

    // Outcome of one instruction from the architectural rules alone.
    function automatic void model(input logic [15:0] ins, input int dly,
                                  output int kind, output logic [31:0] addr,
                                  output logic [31:0] data);
        int off;
        off  = ins[3] ? int'(ins[3:0]) - 16 : int'(ins[3:0]);
        addr = regs[ins[11:8]] + 32'(off);
        data = regs[ins[7:4]];
        if (ins[15:12] != 4'hB) kind = K_ILL;
`ifdef STORE_ALIGN_CHECK_EN
        else if (addr[1:0] != 2'b00) kind = K_MIS;
`endif
        else if (dly >= MAX_WAIT) kind = K_TO;
        else kind = K_DONE;
    endfunction

    task automatic run_txn(input logic [15:0] ins, input int dly, input int kind,
                           input logic [31:0] eaddr, input logic [31:0] edata,
                           input string nm);
        int we_cnt = 0, evt = -1, rdy = -1, pulses = 0, unstable = 0, bad_busy = 0;
        int exp_we, exp_evt, exp_rdy, exp_pulses;
        logic [31:0] a0 = 32'h0, d0 = 32'h0;
        case (kind)
            K_DONE:  begin exp_we = dly + 1;  exp_evt = 5 + dly;      exp_rdy = 6 + dly;      exp_pulses = 1000; end
            K_ILL:   begin exp_we = 0;        exp_evt = 1;            exp_rdy = 2;            exp_pulses = 100;  end
            K_TO:    begin exp_we = MAX_WAIT; exp_evt = 4 + MAX_WAIT; exp_rdy = 4 + MAX_WAIT; exp_pulses = 10;  end
            default: begin exp_we = 0;        exp_evt = 4;            exp_rdy = 4;            exp_pulses = 1;    end
        endcase
        bus.instruction = ins;
        bus.instr_valid = 1'b1;
        bus.mem_ack     = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.instr_valid = 1'b0;
        bus.instruction = 16'($urandom);
        for (int cyc = 1; cyc <= 60; cyc++) begin
            if (bus.busy === bus.instr_ready) bad_busy++;
            if (bus.done)       pulses += 1000;
            if (bus.illegal)    pulses += 100;
            if (bus.timeout)    pulses += 10;
            if (bus.misaligned) pulses += 1;
            if ((bus.done | bus.illegal | bus.timeout | bus.misaligned) && evt < 0) evt = cyc;
            if (bus.mem_we) begin
                we_cnt++;
                if (we_cnt == 1) begin
                    a0 = bus.mem_addr;
                    d0 = bus.mem_wdata;
                end else if (bus.mem_addr !== a0 || bus.mem_wdata !== d0) begin
                    unstable++;
                end
                bus.mem_ack = (we_cnt - 1 == dly);
            end else begin
                bus.mem_ack = 1'($urandom_range(0, 1));
            end
            if (bus.instr_ready) begin
                rdy = cyc;
                break;
            end
            @(negedge clk);
        end
        bus.mem_ack = 1'b0;
        if (kind == K_DONE) exp_count = exp_count + 16'd1;
        check({nm, "_we_cycles"}, we_cnt, exp_we);
        check({nm, "_event_cycle"}, evt, exp_evt);
        check({nm, "_ready_cycle"}, rdy, exp_rdy);
        check({nm, "_pulses"}, pulses, exp_pulses);
        check({nm, "_busy"}, bad_busy, 0);
        check({nm, "_count"}, {16'h0, bus.store_count}, {16'h0, exp_count});
        if (kind == K_DONE || kind == K_TO) begin
            check({nm, "_addr"}, a0, eaddr);
            check({nm, "_wdata"}, d0, edata);
            check({nm, "_stable"}, unstable, 0);
        end
    endtask

    vec_t vt [9];

    initial begin
        int          kind, we;
        logic [31:0] a, d;
        logic [15:0] ins;
        logic [3:0]  op;

        vt[0] = '{16'hB12C, 32'h0000_0100, 32'hDEAD_BEEF, 0,  K_DONE, 32'h0000_00FC};
        vt[1] = '{16'h3120, 32'h0000_0100, 32'h1111_1111, 0,  K_ILL,  32'h0};
        vt[2] = '{16'hB344, 32'h0000_1000, 32'h1234_5678, 3,  K_DONE, 32'h0000_1004};
        vt[3] = '{16'hB568, 32'h0000_0020, 32'hA5A5_5A5A, 14, K_DONE, 32'h0000_0018};
        vt[4] = '{16'hB9A0, 32'h0000_0040, 32'h0BAD_CAFE, 99, K_TO,   32'h0000_0040};
`ifdef STORE_ALIGN_CHECK_EN
        vt[5] = '{16'hB120, 32'h0000_0101, 32'hCAFE_F00D, 0,  K_MIS,  32'h0000_0101};
`else
        vt[5] = '{16'hB120, 32'h0000_0101, 32'hCAFE_F00D, 0,  K_DONE, 32'h0000_0101};
`endif
        vt[6] = '{16'hF000, 32'h0000_0000, 32'h0000_0000, 0,  K_ILL,  32'h0};
        vt[7] = '{16'hB7F7, 32'h0000_1FF9, 32'h7777_0001, 1,  K_DONE, 32'h0000_2000};
        vt[8] = '{16'h0BB0, 32'h0000_0000, 32'h0000_0000, 0,  K_ILL,  32'h0};

        for (int i = 0; i < 16; i++) regs[i] = 32'h0;
        bus.instr_valid = 1'b0;
        bus.instruction = 16'h0000;
        bus.mem_ack     = 1'b0;
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_mem_we", {31'h0, bus.mem_we}, 32'h0);
        check("rst_busy", {31'h0, bus.busy}, 32'h0);
        check("rst_done", {31'h0, bus.done}, 32'h0);
        check("rst_count", {16'h0, bus.store_count}, 32'h0);
        check("rst_mem_addr", bus.mem_addr, 32'h0);
        reset = 1'b1;
        #1 check("rst_release_ready", {31'h0, bus.instr_ready}, 32'h1);
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            regs[vt[i].ins[11:8]] = vt[i].base_v;
            regs[vt[i].ins[7:4]]  = vt[i].data_v;
            run_txn(vt[i].ins, vt[i].dly, vt[i].kind, vt[i].addr, vt[i].data_v,
                    $sformatf("vec%0d", i));
        end

        // Reset landing in the second MEM cycle.
        regs[1] = 32'h0000_0200;
        regs[2] = 32'h0000_55AA;
        bus.instruction = 16'hB120;
        bus.instr_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.instr_valid = 1'b0;
        we = 0;
        for (int c = 0; c < 20; c++) begin
            if (bus.mem_we) we++;
            if (we == 2) break;
            @(negedge clk);
        end
        check("rstmem_reached", we, 2);
        #2 reset = 1'b0;
        #1 check("rstmem_we_drop", {31'h0, bus.mem_we}, 32'h0);
        check("rstmem_busy", {31'h0, bus.busy}, 32'h0);
        check("rstmem_count", {16'h0, bus.store_count}, 32'h0);
        check("rstmem_done", {31'h0, bus.done}, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        exp_count = 16'h0000;
        #1 check("rstmem_ready", {31'h0, bus.instr_ready}, 32'h1);
        @(negedge clk);

        // Counter wrap: preload the count to its maximum, then one more store.
        force dut.store_count_q = 16'hFFFF;
        #1 release dut.store_count_q;
        exp_count = 16'hFFFF;
        regs[1] = 32'h0000_0100;
        regs[2] = 32'hDEAD_BEEF;
        run_txn(16'hB12C, 0, K_DONE, 32'h0000_00FC, 32'hDEAD_BEEF, "wrap");

        for (int n = 0; n < 25; n++) begin
            for (int i = 0; i < 16; i++) regs[i] = $urandom;
            if ($urandom_range(0, 1) == 1) regs[$urandom_range(0, 15)] &= 32'hFFFF_FFF0;
            op = 4'($urandom);
            if ($urandom_range(0, 3) != 0) op = 4'hB;
            ins = {op, 12'($urandom)};
            we = $urandom_range(0, 17);
            model(ins, we, kind, a, d);
            run_txn(ins, we, kind, a, d, $sformatf("rnd%0d", n));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/store_sequencer.md
STORE_SEQUENCER -- requirements
Module: store_sequencer

Interface
REQ-001 Parameter STORE_OPCODE, default 4'b1011, opcode value in instruction[15:12] that identifies a store.
REQ-002 Parameter ALU_ADD, default 3'b010, value driven on alu_control to select addition.
REQ-003 Parameter MAX_WAIT, default 15, maximum number of MEM-state cycles without mem_ack before a timeout.
REQ-004 Port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1, asynchronous active-low reset.
REQ-006 Port instr_valid / instr_ready, input / output, 1 / 1, instruction handshake.
REQ-007 Port instruction, input, 16, [15:12] opcode, [11:8] base register, [7:4] data register, [3:0] signed byte offset.
REQ-008 Port rf_raddr1 / rf_raddr2, output, 4 / 4, register-file read addresses (base / data).
REQ-009 Port rf_rdata1 / rf_rdata2, input, 32 / 32, register-file read data, combinational from the addresses.
REQ-010 Port alu_a / alu_b / alu_control, output, 32 / 32 / 3, ALU operands and operation.
REQ-011 Port alu_result, input, 32, combinational ALU sum.
REQ-012 Port mem_addr / mem_wdata / mem_we, output, 32 / 32 / 1, memory write request.
REQ-013 Port mem_ack, input, 1, memory accepted the write this cycle.
REQ-014 Port busy / done / illegal / timeout / misaligned, output, 1 each, status outputs.
REQ-015 Port store_count, output, 16, count of completed stores.

Function
REQ-016 The FSM SHALL have states IDLE, DECODE, READ, EXEC, MEM and DONE.
REQ-017 In IDLE, instr_ready=1; when instr_valid=1, instruction is latched and the FSM moves to DECODE; instr_ready=0 in all other states.
REQ-018 In DECODE, an opcode not equal to STORE_OPCODE pulses illegal for one cycle and returns to IDLE; otherwise the FSM moves to READ.
REQ-019 In READ, rf_raddr1/rf_raddr2 are driven from the latched fields (held stable from DECODE through MEM); rf_rdata1/rf_rdata2 are registered; the FSM moves to EXEC.
REQ-020 In EXEC: alu_a = registered base; alu_b = offset sign-extended from 4 to 32 bits; alu_control = ALU_ADD; alu_result is registered as the address; the FSM moves to MEM.
REQ-021 In MEM, mem_we=1 with mem_addr and mem_wdata held constant until mem_ack=1, then the FSM moves to DONE.
REQ-022 mem_we=0, and mem_addr/mem_wdata hold their last values, in every state other than MEM.
REQ-023 A wait counter clears on MEM entry and increments on each MEM cycle without mem_ack.
REQ-024 If the wait counter reaches MAX_WAIT without mem_ack, timeout pulses for one cycle, mem_we drops, and the FSM returns to IDLE with store_count unchanged.
REQ-025 A mem_ack in the same cycle the timeout condition is reached takes priority: the store completes.
REQ-026 In DONE, done pulses for one cycle, store_count increments (wrapping 16'hFFFF -> 0), and the FSM returns to IDLE.
REQ-027 busy=1 in every state except IDLE.
REQ-028 With mem_ack high on the first MEM cycle, done is high in the 5th cycle after the acceptance edge, and the next instruction can be accepted one cycle later.
REQ-029 mem_ack outside MEM and instr_valid outside IDLE are ignored.

Reset
REQ-030 reset=0 forces IDLE immediately, regardless of clk.
REQ-031 During reset: all registered outputs, data registers, wait counter and store_count = 0; instr_ready=1 once reset=1.
REQ-032 Reset during MEM drops mem_we immediately, and the aborted store is not counted.

Configuration
REQ-033 Macro STORE_ALIGN_CHECK_EN: when defined, in EXEC a nonzero alu_result[1:0] pulses misaligned for one cycle, skips MEM, and returns to IDLE without counting.
REQ-034 When STORE_ALIGN_CHECK_EN is undefined, misaligned is tied to 0 and unaligned addresses are written unchanged.

Verification
REQ-035 instruction 16'hB12C, rf_rdata1=32'h100, rf_rdata2=32'hDEADBEEF, mem_ack on first MEM cycle -> mem_addr=32'h0FC, mem_wdata=32'hDEADBEEF, done in 5th cycle after accept, store_count=1.
REQ-036 instruction 16'h3120 -> illegal pulses once in the DECODE cycle, mem_we never asserts, store_count unchanged.
REQ-037 mem_ack held 0 with MAX_WAIT=15 -> mem_we high for exactly 15 cycles, then timeout pulses and instr_ready returns to 1.
REQ-038 reset asserted in the 2nd MEM cycle -> mem_we=0 asynchronously, store_count=0, IDLE on release.
REQ-039 rf_rdata1=32'h101, offset 0, STORE_ALIGN_CHECK_EN defined -> misaligned pulses and there is no write; undefined -> write to 32'h101 and done.
REQ-040 store_count preloaded to 16'hFFFF by 65535 stores, then one more store -> store_count=0 and done pulses normally.
